// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - collects NSINK framed batches from a sink stream and replays them on NSINK parallel buses
// Single-buffered: sink_ready drops while the stored run is replayed.
module output_buffer #(
  parameter int NSINK  = 4,
  parameter int WIDTH  = 16,
  parameter int LENGTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sink_valid,
  input  logic                    sink_sop,
  input  logic                    sink_eop,
  input  logic signed [WIDTH-1:0] sink_data,
  output logic                    sink_ready,
  output logic                    sink_error,
  output logic                    source_start,
  output logic                    source_valid,
  output logic signed [WIDTH-1:0] source_data [0:NSINK-1]
);

  localparam int BW = (NSINK > 1) ? $clog2(NSINK) : 1;
  localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(NSINK - 1);
  localparam logic [AW-1:0] A_LAST = AW'(LENGTH - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           b_q, b_d;
  logic [AW-1:0]           a_q, a_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    start_q, start_d;
  logic                    valid_q, valid_d;
  logic signed [WIDTH-1:0] data_q [0:NSINK-1];
  logic signed [WIDTH-1:0] data_d [0:NSINK-1];

  logic                    accept;
  logic                    restart;
  logic [BW-1:0]           eff_b;
  logic [AW-1:0]           eff_a;
  logic                    wr_en;
  logic [BW+AW-1:0]        wr_idx;

  // Address is {bank, entry}, so the array is padded to a power of two.
  logic signed [WIDTH-1:0] mem [0:(1 << (BW + AW)) - 1];

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    a_d     = a_q;
    ready_d = ready_q;
    error_d = 1'b0;
    start_d = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    wr_en   = 1'b0;
    wr_idx  = {b_q, a_q};
    accept  = sink_valid && ready_q;
    restart = (state_q == FILL) && sink_sop && (a_q != '0);
    eff_b   = restart ? '0 : b_q;
    eff_a   = restart ? '0 : a_q;

    case (state_q)
      IDLE, FILL: begin
        if (accept && (sink_sop || state_q == FILL)) begin
          if ((!sink_sop && a_q == '0) || (sink_eop != (eff_a == A_LAST))) begin
            error_d = 1'b1;
            state_d = IDLE;
            b_d     = '0;
            a_d     = '0;
          end else begin
            // A misplaced sop still counts as the first entry of a fresh run.
            error_d = restart;
            wr_en   = 1'b1;
            wr_idx  = {eff_b, eff_a};
            state_d = FILL;
            if (eff_a == A_LAST) begin
              a_d = '0;
              if (eff_b == B_LAST) begin
                b_d     = '0;
                state_d = DRAIN;
                ready_d = 1'b0;
                start_d = 1'b1;
              end else begin
                b_d = eff_b + B_ONE;
              end
            end else begin
              a_d = eff_a + A_ONE;
              b_d = eff_b;
            end
          end
        end
      end
      DRAIN: begin
        // a wraps back to 0 after the last entry; start_q marks the first read.
        if (start_q || a_q != '0) begin
          valid_d = 1'b1;
          for (int i = 0; i < NSINK; i++) begin
            data_d[i] = mem[{BW'(i), a_q}];
          end
          a_d = (a_q == A_LAST) ? '0 : a_q + A_ONE;
        end else begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= sink_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      a_q     <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < NSINK; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      a_q     <= a_d;
      ready_q <= ready_d;
      error_q <= error_d;
      start_q <= start_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign sink_ready   = ready_q;
  assign sink_error   = error_q;
  assign source_start = start_q;
  assign source_valid = valid_q;
  assign source_data  = data_q;

endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - bench for output_buffer: vector table on a 1x1 instance, queue model on a 4x8 instance
module tb_output_buffer;
  localparam int NS = 4;
  localparam int LN = 8;
  localparam int W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, sink_valid, sink_sop, sink_eop;
  logic signed [W-1:0] sink_data;
  logic                sink_ready, sink_error, source_start, source_valid;
  logic signed [W-1:0] source_data [0:NS-1];

  logic                s_reset, s_valid, s_sop, s_eop;
  logic signed [W-1:0] s_data;
  logic                s_ready, s_error, s_start, s_out_valid;
  logic signed [W-1:0] s_out_data [0:0];

  output_buffer #(.NSINK(NS), .WIDTH(W), .LENGTH(LN)) dut (
    .clk(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_data(sink_data), .sink_ready(sink_ready),
    .sink_error(sink_error), .source_start(source_start),
    .source_valid(source_valid), .source_data(source_data)
  );

  output_buffer #(.NSINK(1), .WIDTH(W), .LENGTH(1)) dut_small (
    .clk(clk), .reset(s_reset), .sink_valid(s_valid), .sink_sop(s_sop),
    .sink_eop(s_eop), .sink_data(s_data), .sink_ready(s_ready),
    .sink_error(s_error), .source_start(s_start),
    .source_valid(s_out_valid), .source_data(s_out_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic rst, v, sop, eop;
    logic signed [W-1:0] d;
    logic rdy, err, st, vld;
    logic signed [W-1:0] q;
  } vec_t;

  vec_t tbl [12];

  // Reference model: accepted words are kept in a queue; a run is complete at NS*LN words.
  logic signed [W-1:0] m_cur [$];
  logic signed [W-1:0] m_words [$];
  logic signed [W-1:0] m_data [NS];
  bit m_coll = 1'b0;
  int m_e = -100;
  int m_err_at = -100;

  function automatic bit m_ready(input int c);
    return !(c >= m_e + 1 && c <= m_e + 1 + LN);
  endfunction

  task automatic m_drop_run();
    m_err_at = cyc + 1;
    m_coll = 1'b0;
    m_cur.delete();
  endtask

  task automatic m_step(input logic rst, v, sop, eop, input logic signed [W-1:0] d);
    int a;
    if (rst) begin
      m_coll = 1'b0;
      m_cur.delete();
      m_e = -100;
      m_err_at = -100;
      for (int i = 0; i < NS; i++) m_data[i] = '0;
      return;
    end
    if (!v || !m_ready(cyc)) return;
    if (!m_coll && !sop) return;
    if (!m_coll) m_cur.delete();
    a = m_cur.size() % LN;
    if (sop && a != 0) begin
      m_err_at = cyc + 1;
      m_cur.delete();
      a = 0;
    end else if (!sop && a == 0) begin
      m_drop_run();
      return;
    end
    if (eop != (a == LN - 1)) begin
      m_drop_run();
      return;
    end
    m_cur.push_back(d);
    m_coll = 1'b1;
    if (m_cur.size() == NS * LN) begin
      m_words = m_cur;
      m_cur.delete();
      m_coll = 1'b0;
      m_e = cyc;
    end
  endtask

  task automatic m_check();
    bit vld;
    vld = (cyc >= m_e + 2) && (cyc <= m_e + 1 + LN);
    if (vld) begin
      for (int i = 0; i < NS; i++) m_data[i] = m_words[i * LN + (cyc - m_e - 2)];
    end
    chk("ready", 32'(sink_ready), 32'(m_ready(cyc)));
    chk("error", 32'(sink_error), 32'(cyc == m_err_at));
    chk("start", 32'(source_start), 32'(cyc == m_e + 1));
    chk("valid", 32'(source_valid), 32'(vld));
    for (int i = 0; i < NS; i++) chk("data", 32'(source_data[i]), 32'(m_data[i]));
  endtask

  task automatic tick(input logic rst, v, sop, eop, input logic signed [W-1:0] d);
    reset = rst;
    sink_valid = v;
    sink_sop = sop;
    sink_eop = eop;
    sink_data = d;
    m_step(rst, v, sop, eop, d);
    @(posedge clk);
    #1;
    cyc++;
    m_check();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic signed [W-1:0] val(input int b, input int a);
    return W'(100 * b + a);
  endfunction

  task automatic send_pos(input int idx, input logic signed [W-1:0] d);
    tick(1'b0, 1'b1, (idx % LN) == 0, (idx % LN) == LN - 1, d);
  endtask

  task automatic run(input int gap, input bit neg);
    for (int idx = 0; idx < NS * LN; idx++) begin
      send_pos(idx, neg ? -val(idx / LN, idx % LN) - W'(1) : val(idx / LN, idx % LN));
      idle(gap);
    end
  endtask

  initial begin
    int p;
    logic sop, eop;
    reset = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0;
    s_reset = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = '0;

    //          rst   v     sop   eop   data       rdy   err   st    vld   q
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'sd0,    1'b1, 1'b0, 1'b0, 1'b0, 16'sd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'sd55,   1'b0, 1'b0, 1'b1, 1'b0, 16'sd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'sd0,    1'b0, 1'b0, 1'b0, 1'b1, 16'sd55};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'sd0,    1'b1, 1'b0, 1'b0, 1'b0, 16'sd55};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'sd7,    1'b1, 1'b1, 1'b0, 1'b0, 16'sd55};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'sd9,    1'b1, 1'b0, 1'b0, 1'b0, 16'sd55};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, -16'sd3,   1'b0, 1'b0, 1'b1, 1'b0, 16'sd55};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'sd100,  1'b0, 1'b0, 1'b0, 1'b1, -16'sd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'sd101,  1'b1, 1'b0, 1'b0, 1'b0, -16'sd3};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, -16'sd20,  1'b0, 1'b0, 1'b1, 1'b0, -16'sd3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'sd0,    1'b1, 1'b0, 1'b0, 1'b0, 16'sd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'sd0,    1'b1, 1'b0, 1'b0, 1'b0, 16'sd0};

    for (int i = 0; i < 12; i++) begin
      s_reset = tbl[i].rst;
      s_valid = tbl[i].v;
      s_sop = tbl[i].sop;
      s_eop = tbl[i].eop;
      s_data = tbl[i].d;
      @(posedge clk);
      #1;
      chk("tbl_ready", 32'(s_ready), 32'(tbl[i].rdy));
      chk("tbl_error", 32'(s_error), 32'(tbl[i].err));
      chk("tbl_start", 32'(s_start), 32'(tbl[i].st));
      chk("tbl_valid", 32'(s_out_valid), 32'(tbl[i].vld));
      chk("tbl_data", 32'(s_out_data[0]), 32'(tbl[i].q));
    end
    s_valid = 1'b0;

    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // contiguous run
    run(0, 1'b0);
    idle(12);

    // gapped run after stray non-sop entries
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 16'sd555);
    run(1, 1'b0);
    idle(12);

    // misplaced sop at b=1,a=3 restarts the run
    for (int idx = 0; idx < 11; idx++) send_pos(idx, val(idx / LN, idx % LN));
    tick(1'b0, 1'b1, 1'b1, 1'b0, val(1, 3));
    for (int idx = 1; idx < NS * LN; idx++) send_pos(idx, W'(2000 + idx));
    idle(12);

    // early eop at b=2,a=5 aborts; later non-sop entries are dropped
    for (int idx = 0; idx < 21; idx++) send_pos(idx, val(idx / LN, idx % LN));
    tick(1'b0, 1'b1, 1'b0, 1'b1, val(2, 5));
    repeat (4) tick(1'b0, 1'b1, 1'b0, 1'b0, 16'sd7);
    idle(12);

    // junk during drain, then a back-to-back negative run
    run(0, 1'b0);
    repeat (LN + 1) tick(1'b0, 1'b1, 1'b0, 1'b0, -16'sd1);
    run(0, 1'b1);
    idle(12);

    // reset at E+4 aborts the replay
    run(0, 1'b0);
    idle(3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(12);

    // random framing with occasional corruption and resets
    p = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        p = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        sop = (p % LN) == 0;
        eop = (p % LN) == LN - 1;
        if ($urandom_range(0, 29) == 0) sop = ~sop;
        if ($urandom_range(0, 29) == 0) eop = ~eop;
        tick(1'b0, 1'b1, sop, eop, W'($urandom));
        p = (p + 1) % (NS * LN);
      end
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
